// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if: opcode in, datapath control word and debug state out.
interface control_multiciclo_if;
  logic [5:0] op;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsource, aluop;
  logic [3:0] state;
  modport master (
    input  op,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, illegal,
           alusrcb, pcsource, aluop, state
  );
  modport slave (
    output op,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, illegal,
           alusrcb, pcsource, aluop, state
  );
endinterface

// File: rtl/control_multiciclo.sv
// control_multiciclo: Moore FSM sequencing the multi-cycle MIPS-subset datapath.
module control_multiciclo (
  input logic                  clk,
  input logic                  rst_n,
  control_multiciclo_if.master bus
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;
  state_t     cur, nxt;
  logic       pcw, pcwc, ird, mrd, mwr, irw, m2r, rdst, rw, asa, ill, supported;
  logic [1:0] asb, psrc, aop;
  assign supported = bus.op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: nxt = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                    bus.op == OP_R    ? EXEC   :
                    bus.op == OP_BEQ  ? BRANCH :
                    bus.op == OP_J    ? JUMP   :
                    bus.op == OP_ADDI ? ADDIEX : FETCH;
      MEMADR: nxt = bus.op == OP_LW ? MEMRD : bus.op == OP_SW ? MEMWR : FETCH;
      MEMRD:  nxt = MEMWB;
      EXEC:   nxt = RWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end
  always_comb begin
    {pcw, pcwc, ird, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb  = 2'b00;
    psrc = 2'b00;
    aop  = 2'b00;
    case (cur)
      FETCH:  begin mrd = 1'b1; irw = 1'b1; asb = 2'b01; pcw = 1'b1; end
      DECODE: asb = 2'b11;
      MEMADR, ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      MEMRD:  begin mrd = 1'b1; ird = 1'b1; end
      MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      MEMWR:  begin mwr = 1'b1; ird = 1'b1; end
      EXEC:   begin asa = 1'b1; aop = 2'b10; end
      RWB:    begin rw = 1'b1; rdst = 1'b1; end
      BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      JUMP:   begin pcw = 1'b1; psrc = 2'b10; end
      ADDIWB: rw = 1'b1;
      default: ;
    endcase
  end
  assign ill = cur == DECODE && !supported;
  // Gating by rst_n drops any strobe the instant reset asserts, independent of clk.
  assign bus.pcwrite     = rst_n & pcw;
  assign bus.pcwritecond = rst_n & pcwc;
  assign bus.iord        = rst_n & ird;
  assign bus.memread     = rst_n & mrd;
  assign bus.memwrite    = rst_n & mwr;
  assign bus.irwrite     = rst_n & irw;
  assign bus.memtoreg    = rst_n & m2r;
  assign bus.regdst      = rst_n & rdst;
  assign bus.regwrite    = rst_n & rw;
  assign bus.alusrca     = rst_n & asa;
  assign bus.illegal     = rst_n & ill;
  assign bus.alusrcb     = {2{rst_n}} & asb;
  assign bus.pcsource    = {2{rst_n}} & psrc;
  assign bus.aluop       = {2{rst_n}} & aop;
  assign bus.state       = {4{rst_n}} & cur;
endmodule

// File: tb/tb_control_multiciclo.sv
// tb_control_multiciclo: directed and random instruction streams checked against a CPI/state-table model.
module tb_control_multiciclo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  control_multiciclo_if bus();
  control_multiciclo dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  typedef struct packed {
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic memtoreg, regdst, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsource, aluop;
  } ctl_t;
  typedef int seq_t[$];
  typedef logic [5:0] ops_t[$];

  function automatic seq_t seq_of(logic [5:0] op);
    case (op)
      R:       return '{0, 1, 6, 7};
      LW:      return '{0, 1, 2, 3, 4};
      SW:      return '{0, 1, 2, 5};
      BEQ:     return '{0, 1, 8};
      J:       return '{0, 1, 9};
      ADDI:    return '{0, 1, 10, 11};
      default: return '{0, 1};
    endcase
  endfunction

  function automatic ctl_t model(int s, logic [5:0] op);
    ctl_t c = '0;
    case (s)
      0:  begin c.memread = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.pcwrite = 1; end
      1:  begin c.alusrcb = 2'b11; c.illegal = !(op inside {R, LW, SW, BEQ, J, ADDI}); end
      2, 10: begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  begin c.memread = 1; c.iord = 1; end
      4:  begin c.regwrite = 1; c.memtoreg = 1; end
      5:  begin c.memwrite = 1; c.iord = 1; end
      6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      7:  begin c.regwrite = 1; c.regdst = 1; end
      8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
      9:  begin c.pcwrite = 1; c.pcsource = 2'b10; end
      11: c.regwrite = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.pcwrite = bus.pcwrite; c.pcwritecond = bus.pcwritecond; c.iord = bus.iord;
    c.memread = bus.memread; c.memwrite = bus.memwrite; c.irwrite = bus.irwrite;
    c.memtoreg = bus.memtoreg; c.regdst = bus.regdst; c.regwrite = bus.regwrite;
    c.alusrca = bus.alusrca; c.illegal = bus.illegal; c.alusrcb = bus.alusrcb;
    c.pcsource = bus.pcsource; c.aluop = bus.aluop;
    return c;
  endfunction

  task automatic test_reset();
    ctl_t got;
    bus.op = 6'($urandom());
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = observe();
      total++;
      if (bus.state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
      total++;
      if (got !== ctl_t'(0)) begin bad++; $display("FAIL reset_outputs got=%h exp=0", got); end
    end
    bus.op = R;
    rst_n = 1'b1;
    #1;
    got = observe();
    total++;
    if (got !== model(0, R)) begin bad++; $display("FAIL release_fetch got=%h exp=%h", got, model(0, R)); end
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL release_state got=%0d exp=0", bus.state); end
  endtask

  task automatic test_stream(input ops_t ops, input string tag);
    seq_t seq;
    ctl_t got, exp;
    foreach (ops[n]) begin
      bus.op = ops[n];
      seq = seq_of(ops[n]);
      foreach (seq[k]) begin
        got = observe();
        exp = model(seq[k], ops[n]);
        total++;
        if (bus.state !== 4'(seq[k]))
          begin bad++; $display("FAIL %s_state op=%b cyc=%0d got=%0d exp=%0d", tag, ops[n], k, bus.state, seq[k]); end
        total++;
        if (got !== exp)
          begin bad++; $display("FAIL %s_outputs op=%b st=%0d got=%h exp=%h", tag, ops[n], seq[k], got, exp); end
        total++;
        if (got.memread && got.memwrite)
          begin bad++; $display("FAIL %s_mem_exclusive st=%0d got=11 exp=not both", tag, bus.state); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_midop();
    ctl_t got;
    bus.op = SW;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (bus.memwrite !== 1'b1 || bus.state !== 4'd5)
      begin bad++; $display("FAIL midop_pre got=%0d/%b exp=5/1", bus.state, bus.memwrite); end
    rst_n = 1'b0;
    #1;
    got = observe();
    total++;
    if (bus.memwrite !== 1'b0) begin bad++; $display("FAIL midop_memwrite got=%b exp=0", bus.memwrite); end
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL midop_state got=%0d exp=0", bus.state); end
    total++;
    if (got !== ctl_t'(0)) begin bad++; $display("FAIL midop_outputs got=%h exp=0", got); end
    @(posedge clk); #1;
    total++;
    if (bus.state !== 4'd0 || bus.memwrite !== 1'b0)
      begin bad++; $display("FAIL midop_hold got=%0d/%b exp=0/0", bus.state, bus.memwrite); end
    bus.op = R;
    rst_n = 1'b1;
    #1;
    got = observe();
    total++;
    if (got !== model(0, R)) begin bad++; $display("FAIL midop_release got=%h exp=%h", got, model(0, R)); end
    test_stream('{R}, "post_reset");
  endtask

  initial begin
    ops_t rnd;
    logic [5:0] pick;
    bus.op = R;
    test_reset();
    test_stream('{R, LW, SW, BEQ, J, ADDI, 6'b111111}, "directed");
    test_stream('{SW, SW, BEQ, 6'b000001, LW, LW, J, J}, "back_to_back");
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: pick = R;
        1: pick = LW;
        2: pick = SW;
        3: pick = BEQ;
        4: pick = J;
        5: pick = ADDI;
        default: pick = 6'($urandom());
      endcase
      rnd.push_back(pick);
    end
    test_stream(rnd, "random");
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
